// File: rtl/fifo_stream_pkg.sv
// Shared types and constants for the FIFO stream reader and its output buffer.
package fifo_stream_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      FLUSH = 2'd2
   } state_e;

   localparam int unsigned BUF_DEPTH    = 2;
   localparam int unsigned WORDS_READ_W = 16;
   localparam int unsigned OCC_W        = $clog2(BUF_DEPTH + 1);

   // True while buffered plus in-flight words leave room for one more returned word.
   function automatic logic has_credit(input logic [OCC_W-1:0] occ, input logic inflight);
      return ((OCC_W+1)'(occ) + (OCC_W+1)'(inflight)) < (OCC_W+1)'(BUF_DEPTH);
   endfunction

endpackage

// File: rtl/fifo_stream_skid.sv
// Two-entry output buffer: a head register driving the stream plus one holding slot.
module fifo_stream_skid
   import fifo_stream_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  s_valid_i,
   output logic                  s_ready_o,
   input  logic [DATA_WIDTH-1:0] s_data_i,
   input  logic                  s_last_i,
   output logic                  m_valid_o,
   input  logic                  m_ready_i,
   output logic [DATA_WIDTH-1:0] m_data_o,
   output logic                  m_last_o,
   output logic [OCC_W-1:0]      occ_o
);

   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic                  out_last_q, out_last_d;
   logic                  hold_valid_q, hold_valid_d;
   logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
   logic                  hold_last_q, hold_last_d;
   logic                  pop, push;

   assign s_ready_o = ~hold_valid_q;
   assign m_valid_o = out_valid_q;
   assign m_data_o  = out_data_q;
   assign m_last_o  = out_last_q;
   assign occ_o     = OCC_W'(out_valid_q) + OCC_W'(hold_valid_q);

   // Head only changes when empty or on a beat, so it stays stable under backpressure.
   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_last_d   = out_last_q;
      hold_valid_d = hold_valid_q;
      hold_data_d  = hold_data_q;
      hold_last_d  = hold_last_q;
      pop          = out_valid_q & m_ready_i;
      push         = s_valid_i & ~hold_valid_q;

      if (pop) begin
         if (hold_valid_q) begin
            out_data_d   = hold_data_q;
            out_last_d   = hold_last_q;
            hold_valid_d = 1'b0;
         end else begin
            out_valid_d = 1'b0;
         end
      end

      if (push) begin
         if (!out_valid_q || pop) begin
            out_valid_d = 1'b1;
            out_data_d  = s_data_i;
            out_last_d  = s_last_i;
         end else begin
            hold_valid_d = 1'b1;
            hold_data_d  = s_data_i;
            hold_last_d  = s_last_i;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_last_q   <= 1'b0;
         hold_valid_q <= 1'b0;
         hold_data_q  <= '0;
         hold_last_q  <= 1'b0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_last_q   <= out_last_d;
         hold_valid_q <= hold_valid_d;
         hold_data_q  <= hold_data_d;
         hold_last_q  <= hold_last_d;
      end
   end

endmodule

// File: rtl/fifo_stream_reader.sv
// Reads a FIFO in fixed-length bursts (or drains it on flush) and presents the words
// as a valid/ready stream through a two-entry buffer.
module fifo_stream_reader
   import fifo_stream_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned DEPTH_WIDTH = 8,
   parameter int unsigned BURST_LEN   = 4
) (
   input  logic                    rd_clk,
   input  logic                    rd_rst_n,
   output logic                    fifo_rd_en,
   input  logic [DATA_WIDTH-1:0]   fifo_rd_data,
   input  logic                    fifo_rd_empty,
   input  logic [DEPTH_WIDTH:0]    fifo_rd_water_level,
   input  logic                    flush,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic [DATA_WIDTH-1:0]   m_data,
   output logic                    m_last,
   output logic                    busy,
   output logic [WORDS_READ_W-1:0] words_read,
   output logic                    underflow_err
);

   localparam int unsigned LVL_W = DEPTH_WIDTH + 1;

   state_e                  state_q, state_d;
   logic [LVL_W-1:0]        rem_q, rem_d;
   logic                    flush_pending_q, flush_pending_d;
   logic                    underflow_q, underflow_d;
   logic                    inflight_q, inflight_last_q;
   logic [WORDS_READ_W-1:0] words_read_q;
   logic                    rd_en_c, rd_last_c;
   logic                    skid_ready;
   logic [OCC_W-1:0]        occ;
   logic                    room;

   assign room = skid_ready & has_credit(occ, inflight_q);

   // Read strobe is gated by the live empty flag so no read is ever issued on empty.
   always_comb begin
      state_d         = state_q;
      rem_d           = rem_q;
      flush_pending_d = flush_pending_q | flush;
      underflow_d     = underflow_q;
      rd_en_c         = 1'b0;
      rd_last_c       = 1'b0;

      case (state_q)
         IDLE: begin
            if (flush_pending_q) begin
               state_d = FLUSH;
            end else if (fifo_rd_water_level >= LVL_W'(BURST_LEN)) begin
               state_d = BURST;
               rem_d   = LVL_W'(BURST_LEN);
            end
         end
         BURST: begin
            if (fifo_rd_empty && (rem_q != '0)) begin
               underflow_d = 1'b1;
            end
            if (!fifo_rd_empty && room && (rem_q != '0)) begin
               rd_en_c = 1'b1;
               rem_d   = rem_q - LVL_W'(1);
               if (rem_q == LVL_W'(1)) begin
                  rd_last_c = 1'b1;
                  state_d   = IDLE;
               end
            end
         end
         FLUSH: begin
            if (!fifo_rd_empty && room) begin
               rd_en_c = 1'b1;
            end else if (fifo_rd_empty && !inflight_q) begin
               state_d         = IDLE;
               flush_pending_d = flush;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge rd_clk or negedge rd_rst_n) begin
      if (!rd_rst_n) begin
         state_q         <= IDLE;
         rem_q           <= '0;
         flush_pending_q <= 1'b0;
         underflow_q     <= 1'b0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         words_read_q    <= '0;
      end else begin
         state_q         <= state_d;
         rem_q           <= rem_d;
         flush_pending_q <= flush_pending_d;
         underflow_q     <= underflow_d;
         inflight_q      <= rd_en_c;
         inflight_last_q <= rd_last_c;
         if (rd_en_c) begin
            words_read_q <= words_read_q + WORDS_READ_W'(1);
         end
      end
   end

   fifo_stream_skid #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_skid (
      .clk       (rd_clk),
      .rst_n     (rd_rst_n),
      .s_valid_i (inflight_q),
      .s_ready_o (skid_ready),
      .s_data_i  (fifo_rd_data),
      .s_last_i  (inflight_last_q),
      .m_valid_o (m_valid),
      .m_ready_i (m_ready),
      .m_data_o  (m_data),
      .m_last_o  (m_last),
      .occ_o     (occ)
   );

   assign fifo_rd_en    = rd_en_c;
   assign busy          = (state_q != IDLE) || (occ != '0);
   assign words_read    = words_read_q;
   assign underflow_err = underflow_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural FIFO read port.
module tb_fifo_stream_reader;

   localparam int unsigned DW = 8;
   localparam int unsigned AW = 8;
   localparam int unsigned BL = 4;

   logic          rd_clk = 1'b0;
   logic          rd_rst_n = 1'b0;
   logic          fifo_rd_en;
   logic [DW-1:0] fifo_rd_data = '0;
   logic          fifo_rd_empty;
   logic [AW:0]   fifo_rd_water_level;
   logic          flush = 1'b0;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic [DW-1:0] m_data;
   logic          m_last;
   logic          busy;
   logic [15:0]   words_read;
   logic          underflow_err;

   int total = 0;
   int bad = 0;

   always #5 rd_clk = ~rd_clk;

   fifo_stream_reader #(
      .DATA_WIDTH(DW), .DEPTH_WIDTH(AW), .BURST_LEN(BL)
   ) dut (
      .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .fifo_rd_en(fifo_rd_en),
      .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty),
      .fifo_rd_water_level(fifo_rd_water_level), .flush(flush),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .busy(busy), .words_read(words_read), .underflow_err(underflow_err)
   );

   // FIFO model: read data appears the cycle after the strobe
   logic [DW-1:0] mem [0:63];
   int wr_ptr = 0;
   int rd_ptr = 0;
   bit force_empty = 1'b0;

   assign fifo_rd_water_level = (AW+1)'(wr_ptr - rd_ptr);
   assign fifo_rd_empty = (wr_ptr == rd_ptr) || force_empty;

   always @(posedge rd_clk) begin
      if (fifo_rd_en) begin
         fifo_rd_data <= mem[rd_ptr];
         rd_ptr <= rd_ptr + 1;
      end
   end

   // Monitor: records issued reads and transferred beats
   int cyc = 0;
   int rd_cnt = 0;
   int beat_cnt = 0;
   int viol = 0;
   int rd_cyc [0:127];
   int beat_cyc [0:127];
   logic [DW-1:0] beat_data [0:127];
   logic beat_last [0:127];

   always @(negedge rd_clk) begin
      cyc <= cyc + 1;
      if (fifo_rd_en) begin
         rd_cyc[rd_cnt] <= cyc;
         rd_cnt <= rd_cnt + 1;
      end
      if (fifo_rd_en && fifo_rd_empty) viol <= viol + 1;
      if (m_valid && m_ready) begin
         beat_data[beat_cnt] <= m_data;
         beat_last[beat_cnt] <= m_last;
         beat_cyc[beat_cnt] <= cyc;
         beat_cnt <= beat_cnt + 1;
      end
   end

   task automatic tick();
      @(posedge rd_clk);
      #1;
   endtask

   task automatic push_words(input int n, input logic [DW-1:0] base);
      for (int i = 0; i < n; i++) mem[wr_ptr + i] = base + DW'(i);
      wr_ptr = wr_ptr + n;
   endtask

   task automatic wait_done(input int b0, input int n, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if ((beat_cnt - b0) >= n && !busy) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rd_rst_n = 1'b0;
      repeat (3) tick();
      total++;
      if ({fifo_rd_en, m_valid, m_last, busy, underflow_err} !== 5'b0) begin
         bad++; $display("FAIL reset_flags got=%b exp=00000", {fifo_rd_en, m_valid, m_last, busy, underflow_err});
      end
      total++;
      if (m_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%0h exp=0", m_data); end
      total++;
      if (words_read !== 16'd0) begin bad++; $display("FAIL reset_words got=%0d exp=0", words_read); end
      rd_rst_n = 1'b1;
      tick();
      tick();
   endtask

   task automatic test_burst();
      int b0, r0;
      bit ok;
      logic [3:0] lv;
      b0 = beat_cnt; r0 = rd_cnt;
      m_ready = 1'b1;
      push_words(4, 8'h10);
      wait_done(b0, 4, ok);
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL burst_timeout got=%0d exp=1", ok); end
      total++; if (rd_cnt - r0 !== 4) begin bad++; $display("FAIL burst_reads got=%0d exp=4", rd_cnt - r0); end
      total++; if (beat_cnt - b0 !== 4) begin bad++; $display("FAIL burst_beats got=%0d exp=4", beat_cnt - b0); end
      for (int i = 0; i < 4; i++) begin
         lv[i] = beat_last[b0 + i];
         total++;
         if (beat_data[b0 + i] !== 8'h10 + DW'(i)) begin
            bad++; $display("FAIL burst_data[%0d] got=%0h exp=%0h", i, beat_data[b0 + i], 8'h10 + DW'(i));
         end
      end
      total++; if (lv !== 4'b1000) begin bad++; $display("FAIL burst_last got=%b exp=1000", lv); end
      total++; if (words_read !== 16'd4) begin bad++; $display("FAIL burst_words got=%0d exp=4", words_read); end
      total++;
      if (beat_cyc[b0] - rd_cyc[r0] !== 2) begin
         bad++; $display("FAIL burst_latency got=%0d exp=2", beat_cyc[b0] - rd_cyc[r0]);
      end
   endtask

   task automatic test_backpressure();
      int b0, r0;
      bit ok;
      logic [3:0] lv;
      b0 = beat_cnt; r0 = rd_cnt;
      m_ready = 1'b0;
      push_words(4, 8'h20);
      repeat (10) tick();
      total++; if (rd_cnt - r0 !== 2) begin bad++; $display("FAIL bp_stall_reads got=%0d exp=2", rd_cnt - r0); end
      total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL bp_valid got=%0d exp=1", m_valid); end
      total++; if (m_data !== 8'h20) begin bad++; $display("FAIL bp_hold_data got=%0h exp=20", m_data); end
      total++; if (beat_cnt - b0 !== 0) begin bad++; $display("FAIL bp_no_beats got=%0d exp=0", beat_cnt - b0); end
      m_ready = 1'b1;
      wait_done(b0, 4, ok);
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL bp_timeout got=%0d exp=1", ok); end
      total++; if (rd_cnt - r0 !== 4) begin bad++; $display("FAIL bp_reads got=%0d exp=4", rd_cnt - r0); end
      for (int i = 0; i < 4; i++) begin
         lv[i] = beat_last[b0 + i];
         total++;
         if (beat_data[b0 + i] !== 8'h20 + DW'(i)) begin
            bad++; $display("FAIL bp_data[%0d] got=%0h exp=%0h", i, beat_data[b0 + i], 8'h20 + DW'(i));
         end
      end
      total++; if (lv !== 4'b1000) begin bad++; $display("FAIL bp_last got=%b exp=1000", lv); end
      total++; if (words_read !== 16'd8) begin bad++; $display("FAIL bp_words got=%0d exp=8", words_read); end
   endtask

   task automatic test_flush();
      int b0, r0;
      bit ok;
      logic [2:0] lv;
      b0 = beat_cnt; r0 = rd_cnt;
      m_ready = 1'b1;
      push_words(3, 8'h30);
      repeat (5) tick();
      total++; if (rd_cnt - r0 !== 0) begin bad++; $display("FAIL flush_below_level got=%0d exp=0", rd_cnt - r0); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_idle_busy got=%0d exp=0", busy); end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      wait_done(b0, 3, ok);
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL flush_timeout got=%0d exp=1", ok); end
      total++; if (rd_cnt - r0 !== 3) begin bad++; $display("FAIL flush_reads got=%0d exp=3", rd_cnt - r0); end
      total++; if (beat_cnt - b0 !== 3) begin bad++; $display("FAIL flush_beats got=%0d exp=3", beat_cnt - b0); end
      for (int i = 0; i < 3; i++) begin
         lv[i] = beat_last[b0 + i];
         total++;
         if (beat_data[b0 + i] !== 8'h30 + DW'(i)) begin
            bad++; $display("FAIL flush_data[%0d] got=%0h exp=%0h", i, beat_data[b0 + i], 8'h30 + DW'(i));
         end
      end
      total++; if (lv !== 3'b000) begin bad++; $display("FAIL flush_last got=%b exp=000", lv); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%0d exp=0", busy); end
      total++; if (words_read !== 16'd11) begin bad++; $display("FAIL flush_words got=%0d exp=11", words_read); end
   endtask

   task automatic test_flush_mid_burst();
      int b0, r0;
      bit ok;
      logic [5:0] lv;
      b0 = beat_cnt; r0 = rd_cnt;
      m_ready = 1'b1;
      push_words(6, 8'h40);
      for (int i = 0; i < 50; i++) begin
         tick();
         if (beat_cnt - b0 >= 2) break;
      end
      total++; if (beat_cnt - b0 !== 2) begin bad++; $display("FAIL mid_beat2 got=%0d exp=2", beat_cnt - b0); end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      wait_done(b0, 6, ok);
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL mid_timeout got=%0d exp=1", ok); end
      total++; if (rd_cnt - r0 !== 6) begin bad++; $display("FAIL mid_reads got=%0d exp=6", rd_cnt - r0); end
      total++; if (beat_cnt - b0 !== 6) begin bad++; $display("FAIL mid_beats got=%0d exp=6", beat_cnt - b0); end
      for (int i = 0; i < 6; i++) begin
         lv[i] = beat_last[b0 + i];
         total++;
         if (beat_data[b0 + i] !== 8'h40 + DW'(i)) begin
            bad++; $display("FAIL mid_data[%0d] got=%0h exp=%0h", i, beat_data[b0 + i], 8'h40 + DW'(i));
         end
      end
      total++; if (lv !== 6'b001000) begin bad++; $display("FAIL mid_last got=%b exp=001000", lv); end
      total++; if (words_read !== 16'd17) begin bad++; $display("FAIL mid_words got=%0d exp=17", words_read); end
   endtask

   task automatic test_reset_mid_burst();
      int b0, r0;
      bit ok;
      logic [3:0] lv;
      r0 = rd_cnt;
      m_ready = 1'b1;
      push_words(4, 8'h50);
      for (int i = 0; i < 50; i++) begin
         tick();
         if (rd_cnt - r0 >= 2) break;
      end
      total++; if (rd_cnt - r0 !== 2) begin bad++; $display("FAIL rst_pre_reads got=%0d exp=2", rd_cnt - r0); end
      rd_rst_n = 1'b0;
      #1;
      total++;
      if ({fifo_rd_en, m_valid, m_last, busy, underflow_err} !== 5'b0) begin
         bad++; $display("FAIL rst_mid_flags got=%b exp=00000", {fifo_rd_en, m_valid, m_last, busy, underflow_err});
      end
      total++; if (m_data !== 8'h00) begin bad++; $display("FAIL rst_mid_data got=%0h exp=0", m_data); end
      total++; if (words_read !== 16'd0) begin bad++; $display("FAIL rst_mid_words got=%0d exp=0", words_read); end
      push_words(2, 8'h54);
      tick();
      tick();
      b0 = beat_cnt; r0 = rd_cnt;
      rd_rst_n = 1'b1;
      @(negedge rd_clk);
      total++; if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL rst_rel_edge1 got=%0d exp=0", fifo_rd_en); end
      @(negedge rd_clk);
      total++; if (fifo_rd_en !== 1'b1) begin bad++; $display("FAIL rst_rel_edge2 got=%0d exp=1", fifo_rd_en); end
      wait_done(b0, 4, ok);
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL rst_timeout got=%0d exp=1", ok); end
      total++; if (rd_cnt - r0 !== 4) begin bad++; $display("FAIL rst_reads got=%0d exp=4", rd_cnt - r0); end
      for (int i = 0; i < 4; i++) begin
         lv[i] = beat_last[b0 + i];
         total++;
         if (beat_data[b0 + i] !== 8'h52 + DW'(i)) begin
            bad++; $display("FAIL rst_data[%0d] got=%0h exp=%0h", i, beat_data[b0 + i], 8'h52 + DW'(i));
         end
      end
      total++; if (lv !== 4'b1000) begin bad++; $display("FAIL rst_last got=%b exp=1000", lv); end
      total++; if (words_read !== 16'd4) begin bad++; $display("FAIL rst_words got=%0d exp=4", words_read); end
      total++; if (underflow_err !== 1'b0) begin bad++; $display("FAIL rst_underflow got=%0d exp=0", underflow_err); end
   endtask

   task automatic test_underflow();
      int b0, r0;
      bit ok;
      b0 = beat_cnt; r0 = rd_cnt;
      m_ready = 1'b1;
      force_empty = 1'b1;
      push_words(4, 8'h60);
      repeat (6) tick();
      total++; if (underflow_err !== 1'b1) begin bad++; $display("FAIL uf_flag got=%0d exp=1", underflow_err); end
      total++; if (rd_cnt - r0 !== 0) begin bad++; $display("FAIL uf_no_reads got=%0d exp=0", rd_cnt - r0); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL uf_busy got=%0d exp=1", busy); end
      force_empty = 1'b0;
      wait_done(b0, 4, ok);
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL uf_timeout got=%0d exp=1", ok); end
      total++; if (underflow_err !== 1'b1) begin bad++; $display("FAIL uf_sticky got=%0d exp=1", underflow_err); end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (beat_data[b0 + i] !== 8'h60 + DW'(i)) begin
            bad++; $display("FAIL uf_data[%0d] got=%0h exp=%0h", i, beat_data[b0 + i], 8'h60 + DW'(i));
         end
      end
      total++; if (words_read !== 16'd8) begin bad++; $display("FAIL uf_words got=%0d exp=8", words_read); end
      total++; if (viol !== 0) begin bad++; $display("FAIL rd_on_empty got=%0d exp=0", viol); end
   endtask

   initial begin
      test_reset();
      test_burst();
      test_backpressure();
      test_flush();
      test_flush_mid_burst();
      test_reset_mid_burst();
      test_underflow();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fifo_stream_reader.md
FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the FIFO read data and stream data width.
REQ-002 SHALL have parameter DEPTH_WIDTH, default 8, the FIFO address width; the water level is DEPTH_WIDTH+1 bits.
REQ-003 SHALL have parameter BURST_LEN, default 4, the words per burst, legal range 1..2^DEPTH_WIDTH.
REQ-004 SHALL have port rd_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port rd_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port fifo_rd_en, output, 1 bit: read strobe to the FIFO read port.
REQ-007 SHALL have port fifo_rd_data, input, DATA_WIDTH: FIFO data, valid 1 cycle after fifo_rd_en (no output register).
REQ-008 SHALL have port fifo_rd_empty, input, 1 bit: FIFO empty flag.
REQ-009 SHALL have port fifo_rd_water_level, input, DEPTH_WIDTH+1: FIFO read-side word count.
REQ-010 SHALL have port flush, input, 1 bit: single-cycle request to drain the FIFO regardless of level.
REQ-011 SHALL have port m_valid, output, 1 bit: stream data valid.
REQ-012 SHALL have port m_ready, input, 1 bit: stream sink ready.
REQ-013 SHALL have port m_data, output, DATA_WIDTH: stream data.
REQ-014 SHALL have port m_last, output, 1 bit: high with the final word of each burst.
REQ-015 SHALL have port busy, output, 1 bit: FSM is not IDLE or the buffer is non-empty.
REQ-016 SHALL have port words_read, output, 16 bits: count of FIFO reads issued, wrapping modulo 2^16.
REQ-017 SHALL have port underflow_err, output, 1 bit: sticky error flag.

Function
REQ-018 SHALL transfer a stream beat on any cycle with m_valid=1 and m_ready=1; m_data and m_last SHALL hold stable while m_valid=1 and m_ready=0.
REQ-019 SHALL buffer words in a 2-entry output buffer.
REQ-020 SHALL assert fifo_rd_en only when fifo_rd_empty=0, the FSM is in BURST or FLUSH, and buffer occupancy plus in-flight reads is less than 2, so no returned word is ever dropped.
REQ-021 SHALL capture fifo_rd_data into the buffer on the cycle after each fifo_rd_en; the best-case fifo_rd_en to m_valid latency is 2 cycles.
REQ-022 SHALL implement FSM states IDLE, BURST and FLUSH.
REQ-023 SHALL, in IDLE, move to FLUSH if flush_pending=1, else to BURST when fifo_rd_water_level >= BURST_LEN; when moving to BURST it loads the remaining-read counter with BURST_LEN.
REQ-024 SHALL, in BURST, decrement the remaining-read counter on each fifo_rd_en and return to IDLE on the cycle the last read issues.
REQ-025 SHALL tag the word from the BURST_LEN-th read of a burst with m_last=1.
REQ-026 SHALL, in FLUSH, read until fifo_rd_empty=1 with no read in flight, then clear flush_pending and return to IDLE; m_last stays 0 for flushed words.
REQ-027 SHALL latch flush into flush_pending in any state; a flush arriving during BURST is serviced after that burst completes.
REQ-028 SHALL set underflow_err if fifo_rd_empty=1 while in BURST with the remaining-read counter > 0; the flag clears only on reset.
REQ-029 SHALL NOT assert fifo_rd_en while fifo_rd_empty=1 under any condition.
REQ-030 SHALL allow capture into the buffer and a stream beat on the same cycle, leaving occupancy unchanged.

Reset
REQ-031 SHALL, while rd_rst_n=0, asynchronously force fifo_rd_en=0, m_valid=0, m_data=0, m_last=0, busy=0, words_read=0, underflow_err=0, state=IDLE, flush_pending=0 and buffer occupancy 0.
REQ-032 SHALL discard a read in flight when reset asserts mid-operation; the word is lost by design.
REQ-033 SHALL have reset release take effect synchronously to rd_clk, with the first read no earlier than the second rising edge after release.

Structure
REQ-034 SHALL place the FSM state enum (IDLE, BURST, FLUSH), the buffer depth constant (2) and the words_read width constant (16) in shared package fifo_stream_pkg.
REQ-035 SHALL implement the 2-entry buffer as sub-module fifo_stream_skid, which holds data plus last bit and has valid/ready on both sides.

Verification
REQ-036 SHALL cover: level 4, m_ready=1 -> 4 fifo_rd_en pulses, 4 beats, m_last only on beat 4, words_read=4.
REQ-037 SHALL cover: level 4, m_ready=0 for 10 cycles -> exactly 2 reads issued, then stall, no data loss; releasing m_ready yields all 4 words in order.
REQ-038 SHALL cover: level 3, flush pulse -> FLUSH state, 3 beats, m_last never set, return to IDLE, busy=0.
REQ-039 SHALL cover: flush pulse at burst beat 2 with level 6 -> burst of 4 with m_last, then flush of remaining 2.
REQ-040 SHALL cover: rd_rst_n low mid-burst -> all outputs 0 in the same cycle; after release, level 4 restarts a fresh burst.
REQ-041 SHALL cover: fifo_rd_empty forced 1 during BURST -> underflow_err=1 sticky, fifo_rd_en held 0.
